// File: rtl/a2d_pkg.sv
// Shared types and helpers for the round-robin A2D sampler.
package a2d_pkg;

    // Sequencer states: command frame, one-cycle gap, response frame.
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        RESP
    } a2d_state_t;

    localparam int RES_W = 12;
    localparam int CMD_W = 16;

    // A2D read command: channel number sits in bits [13:11], rest zero.
    function automatic logic [CMD_W-1:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// SPI master (mode 3): 16-bit frames, SCLK = clk/4, MOSI changes on the
// falling SCLK edge and MISO is sampled on the rising edge. SCLK idles high
// and stays high for two clocks after SS_n falls.
module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] resp
);

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_BACK
    } spi_state_t;

    spi_state_t  state;
    logic [1:0]  div;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic        miso_smpl;

    // Frame sequencer: shift out cmd while shifting in the slave's reply.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= SPI_IDLE;
            div       <= 2'd0;
            bit_cnt   <= 4'd0;
            shreg     <= 16'h0000;
            miso_smpl <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (snd) begin
                        shreg   <= cmd;
                        div     <= 2'd0;
                        bit_cnt <= 4'd0;
                        state   <= SPI_SHIFT;
                    end
                end
                SPI_SHIFT: begin
                    div <= div + 2'd1;
                    // Falling edge: shift in the bit sampled at the previous
                    // rise; the first fall has nothing to shift yet.
                    if (div == 2'd1 && bit_cnt != 4'd0) begin
                        shreg <= {shreg[14:0], miso_smpl};
                    end
                    // Rising edge: sample MISO and count the bit.
                    if (div == 2'd3) begin
                        miso_smpl <= MISO;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state <= SPI_BACK;
                        end
                    end
                end
                SPI_BACK: begin
                    shreg <= {shreg[14:0], miso_smpl};
                    done  <= 1'b1;
                    state <= SPI_IDLE;
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

    assign SS_n = (state == SPI_IDLE);
    assign SCLK = (state == SPI_SHIFT) ? ~div[1] : 1'b1;
    assign MOSI = shreg[15];
    assign resp = shreg;

endmodule

// File: rtl/a2d_rr_sampler.sv
// Round-robin A2D sampler: every 2^PERIOD_W cycles converts the next slot's
// channel with a command frame followed by a dummy frame that clocks the
// reply out, then updates that slot's (optionally EMA-smoothed) result.
module a2d_rr_sampler
    import a2d_pkg::*;
#(
    parameter int                  NUM_CH    = 4,
    parameter logic [NUM_CH*3-1:0] CH_MAP    = {3'd4, 3'd3, 3'd1, 3'd0},
    parameter int                  PERIOD_W  = 14,
    parameter int                  AVG_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    MISO,
    output logic                    SS_n,
    output logic                    SCLK,
    output logic                    MOSI,
    output logic [NUM_CH*RES_W-1:0] result,
    output logic [NUM_CH-1:0]       smpl_vld,
    output logic [2:0]              slot
);

    localparam int         ACC_W     = RES_W + AVG_SHIFT;
    localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

    logic [PERIOD_W-1:0] interval_cnt;
    logic                tick;
    a2d_state_t          state;
    logic                snd;
    logic                done;
    logic [CMD_W-1:0]    cmd;
    logic [CMD_W-1:0]    resp;
    logic                capture;
    logic [ACC_W-1:0]    sample_ext;
    logic                unused_resp_bits;

    // Free-running interval counter; all-ones marks a conversion slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + PERIOD_W'(1);
        end
    end

    assign tick = &interval_cnt;

    // snd is decoded from state so the command frame starts in the tick cycle
    // itself and the dummy frame exactly one clock after the CMD done.
    assign snd     = (state == IDLE && tick && en) || (state == GAP);
    assign capture = (state == RESP) && done;

    // slot is stable for the whole transaction, so cmd is too.
    assign cmd = a2d_cmd(CH_MAP[slot*3 +: 3]);

    // Transaction sequencer and slot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= 3'd0;
        end else begin
            case (state)
                IDLE: if (tick && en) state <= CMD;
                CMD:  if (done) state <= GAP;
                GAP:  state <= RESP;
                RESP: begin
                    if (done) begin
                        state <= IDLE;
                        slot  <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    SPI_mnrch u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .snd   (snd),
        .cmd   (cmd),
        .MISO  (MISO),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .done  (done),
        .resp  (resp)
    );

    assign sample_ext       = ACC_W'(resp[RES_W-1:0]);
    assign unused_resp_bits = ^resp[CMD_W-1:RES_W];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        logic [ACC_W-1:0] acc;
        logic             seeded;
        logic             vld_q;
        logic             hit;

        assign hit = capture && (slot == 3'(i));

        // Per-slot EMA: seed with the first sample, then blend in new ones.
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: the accumulators are few, so they take the async reset
            // like any other state and a fresh run never sees stale averages.
            if (!rst_n) begin
                acc    <= '0;
                seeded <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= hit;
                if (hit) begin
                    acc    <= seeded ? (acc - (acc >> AVG_SHIFT) + sample_ext)
                                     : (sample_ext << AVG_SHIFT);
                    seeded <= 1'b1;
                end
            end
        end

        assign result[i*RES_W +: RES_W] = acc[AVG_SHIFT +: RES_W];
        assign smpl_vld[i]              = vld_q;
    end

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Directed bench for a2d_rr_sampler. Three instances share clock, reset and
// enable so their SPI timing runs in lockstep; one A2D model serves all three.
module tb_a2d_rr_sampler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;

    logic [2:0] miso_v = 3'b000;
    logic [2:0] mosi_v;

    logic        ss_n_a, sclk_a;
    logic [47:0] result_a;
    logic [3:0]  smpl_vld_a;
    logic [2:0]  slot_a;

    logic        unused_ss_n_b, unused_sclk_b;
    logic [35:0] result_b;
    logic [2:0]  smpl_vld_b;
    logic [2:0]  slot_b;

    logic        unused_ss_n_c, unused_sclk_c;
    logic [47:0] result_c;
    logic [3:0]  smpl_vld_c;
    logic [2:0]  slot_c;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    a2d_rr_sampler #(.PERIOD_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .MISO(miso_v[0]),
        .SS_n(ss_n_a), .SCLK(sclk_a), .MOSI(mosi_v[0]),
        .result(result_a), .smpl_vld(smpl_vld_a), .slot(slot_a)
    );

    a2d_rr_sampler #(.NUM_CH(3), .CH_MAP({3'd7, 3'd2, 3'd5}), .PERIOD_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .MISO(miso_v[1]),
        .SS_n(unused_ss_n_b), .SCLK(unused_sclk_b), .MOSI(mosi_v[1]),
        .result(result_b), .smpl_vld(smpl_vld_b), .slot(slot_b)
    );

    a2d_rr_sampler #(.PERIOD_W(8), .AVG_SHIFT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .MISO(miso_v[2]),
        .SS_n(unused_ss_n_c), .SCLK(unused_sclk_c), .MOSI(mosi_v[2]),
        .result(result_c), .smpl_vld(smpl_vld_c), .slot(slot_c)
    );

    // ---------------- A2D model ----------------
    // Replies during each frame with the value of the channel named by the
    // previous frame's command; logs every received MOSI frame.
    logic [11:0] adc [3][8];
    logic [15:0] tx [3];
    logic [15:0] rx [3];
    logic [2:0]  ch_q [3];
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic [15:0] log0 [$];
    logic [15:0] log1 [$];
    logic [15:0] log2 [$];
    int          frames_started = 0;
    int          base0, base1, base2;

    initial begin
        for (int i = 0; i < 3; i++) begin
            tx[i] = 16'h0; rx[i] = 16'h0; ch_q[i] = 3'd0;
            for (int c = 0; c < 8; c++) adc[i][c] = 12'h000;
        end
        adc[0][0] = 12'hABC; adc[0][1] = 12'h123; adc[0][3] = 12'h456; adc[0][4] = 12'h789;
        adc[1][5] = 12'h111; adc[1][2] = 12'h222; adc[1][7] = 12'h333;
        adc[2][0] = 12'h400;
    end

    always @(ss_n_a or sclk_a) begin
        if (ss_prev === 1'b1 && ss_n_a === 1'b0) begin
            frames_started++;
            for (int i = 0; i < 3; i++) tx[i] = {4'h0, adc[i][ch_q[i]]};
        end else if (ss_prev === 1'b0 && ss_n_a === 1'b1) begin
            for (int i = 0; i < 3; i++) ch_q[i] = rx[i][13:11];
            log0.push_back(rx[0]);
            log1.push_back(rx[1]);
            log2.push_back(rx[2]);
        end
        if (ss_n_a === 1'b0 && sclk_prev === 1'b1 && sclk_a === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                miso_v[i] = tx[i][15];
                tx[i] = tx[i] << 1;
            end
        end
        if (ss_n_a === 1'b0 && sclk_prev === 1'b0 && sclk_a === 1'b1) begin
            for (int i = 0; i < 3; i++) rx[i] = {rx[i][14:0], mosi_v[i]};
        end
        ss_prev   = ss_n_a;
        sclk_prev = sclk_a;
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        base0 = log0.size();
        base1 = log1.size();
        base2 = log2.size();
        rst_n = 1'b1;
    endtask

    // Wait for the next smpl_vld pulse (all instances convert in lockstep).
    task automatic wait_conv();
        int n = 0;
        @(posedge clk); #1;
        while (smpl_vld_a == '0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (smpl_vld_a == '0) begin
            checks++; fails++;
            $display("FAIL conv_timeout: smpl_vld stayed %b for 600 cycles, expected a pulse", smpl_vld_a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (ss_n_a !== 1'b1) begin fails++; $display("FAIL rst_ss_n: got %b expected 1", ss_n_a); end
        checks++; if (sclk_a !== 1'b1) begin fails++; $display("FAIL rst_sclk: got %b expected 1", sclk_a); end
        checks++; if (result_a !== 48'h0) begin fails++; $display("FAIL rst_result: got %h expected 0", result_a); end
        checks++; if (smpl_vld_a !== 4'b0) begin fails++; $display("FAIL rst_vld: got %b expected 0000", smpl_vld_a); end
        checks++; if (slot_a !== 3'd0) begin fails++; $display("FAIL rst_slot: got %0d expected 0", slot_a); end
        @(negedge clk); rst_n = 1'b1;
        wait_conv();
        checks++; if (result_a[11:0] !== 12'hABC) begin fails++; $display("FAIL pre_reset_result: got %h expected abc", result_a[11:0]); end
        checks++; if (slot_a !== 3'd1) begin fails++; $display("FAIL pre_reset_slot: got %0d expected 1", slot_a); end
        n = 0;
        while (ss_n_a && n < 400) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ss_n_a !== 1'b1) begin fails++; $display("FAIL midframe_ss_n: got %b expected 1", ss_n_a); end
        checks++; if (result_a !== 48'h0) begin fails++; $display("FAIL midframe_result: got %h expected 0", result_a); end
        checks++; if (smpl_vld_a !== 4'b0) begin fails++; $display("FAIL midframe_vld: got %b expected 0000", smpl_vld_a); end
        checks++; if (slot_a !== 3'd0) begin fails++; $display("FAIL midframe_slot: got %0d expected 0", slot_a); end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (ss_n_a && n < 1000);
        checks++; if (n != 256) begin fails++; $display("FAIL first_snd_latency: got %0d cycles expected 256", n); end
    endtask

    task automatic test_default();
        do_reset();
        wait_conv();
        checks++; if (result_a[11:0] !== 12'hABC) begin fails++; $display("FAIL dflt_result: got %h expected abc", result_a[11:0]); end
        checks++; if (result_a[47:12] !== 36'h0) begin fails++; $display("FAIL dflt_others: got %h expected 0", result_a[47:12]); end
        checks++; if (smpl_vld_a !== 4'b0001) begin fails++; $display("FAIL dflt_vld: got %b expected 0001", smpl_vld_a); end
        checks++; if (log0.size() < base0 + 2 || log0[base0] !== 16'h0000 || log0[base0+1] !== 16'h0000) begin
            fails++; $display("FAIL dflt_mosi: got %0d frames, first %h expected two frames of 0000", log0.size() - base0, (log0.size() > base0) ? log0[base0] : 16'hxxxx);
        end
        @(posedge clk); #1;
        checks++; if (smpl_vld_a !== 4'b0000) begin fails++; $display("FAIL dflt_vld_width: got %b expected 0000", smpl_vld_a); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_cmd [5];
        logic [11:0] exp_dat [5];
        exp_cmd = '{16'h0000, 16'h0800, 16'h1800, 16'h2000, 16'h0000};
        exp_dat = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'h5A5};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) adc[0][0] = 12'h5A5;
            wait_conv();
            checks++; if (smpl_vld_a !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_vld[%0d]: got %b expected %b", k, smpl_vld_a, 4'(1 << (k % 4))); end
            checks++; if (result_a[(k%4)*12 +: 12] !== exp_dat[k]) begin fails++; $display("FAIL rr_result[%0d]: got %h expected %h", k, result_a[(k%4)*12 +: 12], exp_dat[k]); end
            checks++; if (slot_a !== 3'((k + 1) % 4)) begin fails++; $display("FAIL rr_slot[%0d]: got %0d expected %0d", k, slot_a, (k + 1) % 4); end
            checks++; if (log0.size() < base0 + 2*k + 2 || log0[base0+2*k] !== exp_cmd[k] || log0[base0+2*k+1] !== exp_cmd[k]) begin
                fails++; $display("FAIL rr_mosi[%0d]: got %0d frames expected cmd %h twice", k, log0.size() - base0, exp_cmd[k]);
            end
        end
        adc[0][0] = 12'hABC;
    endtask

    task automatic test_num_ch3();
        logic [15:0] exp_cmd [4];
        logic [11:0] exp_dat [4];
        exp_cmd = '{16'h2800, 16'h1000, 16'h3800, 16'h2800};
        exp_dat = '{12'h111, 12'h222, 12'h333, 12'h111};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_conv();
            checks++; if (smpl_vld_b !== 3'(1 << (k % 3))) begin fails++; $display("FAIL ch3_vld[%0d]: got %b expected %b", k, smpl_vld_b, 3'(1 << (k % 3))); end
            checks++; if (result_b[(k%3)*12 +: 12] !== exp_dat[k]) begin fails++; $display("FAIL ch3_result[%0d]: got %h expected %h", k, result_b[(k%3)*12 +: 12], exp_dat[k]); end
            checks++; if (slot_b !== 3'((k + 1) % 3)) begin fails++; $display("FAIL ch3_slot[%0d]: got %0d expected %0d", k, slot_b, (k + 1) % 3); end
            checks++; if (log1.size() < base1 + 2*k + 2 || log1[base1+2*k] !== exp_cmd[k] || log1[base1+2*k+1] !== exp_cmd[k]) begin
                fails++; $display("FAIL ch3_mosi[%0d]: got %0d frames expected cmd %h twice", k, log1.size() - base1, exp_cmd[k]);
            end
        end
    endtask

    task automatic test_ema();
        adc[2][0] = 12'h400;
        do_reset();
        wait_conv();
        checks++; if (smpl_vld_c !== 4'b0001) begin fails++; $display("FAIL ema_vld: got %b expected 0001", smpl_vld_c); end
        checks++; if (result_c[11:0] !== 12'h400) begin fails++; $display("FAIL ema_seed: got %h expected 400", result_c[11:0]); end
        adc[2][0] = 12'h800;
        repeat (4) wait_conv();
        checks++; if (smpl_vld_c !== 4'b0001) begin fails++; $display("FAIL ema_vld2: got %b expected 0001", smpl_vld_c); end
        checks++; if (result_c[11:0] !== 12'h500) begin fails++; $display("FAIL ema_blend: got %h expected 500", result_c[11:0]); end
        checks++; if (log2.size() < base2 + 10 || log2[base2+8] !== 16'h0000) begin fails++; $display("FAIL ema_mosi: got %0d frames expected 10 with slot-0 cmd 0000", log2.size() - base2); end
    endtask

    task automatic test_enable();
        int n, f0;
        en = 1'b0;
        do_reset();
        f0 = frames_started;
        repeat (300) @(posedge clk); #1;
        checks++; if (frames_started - f0 != 0) begin fails++; $display("FAIL en_low_frames: got %0d expected 0", frames_started - f0); end
        checks++; if (slot_a !== 3'd0) begin fails++; $display("FAIL en_low_slot: got %0d expected 0", slot_a); end
        en = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++; if (ss_n_a !== 1'b1) begin fails++; $display("FAIL no_catch_up: got SS_n %b expected 1", ss_n_a); end
        n = 0;
        while (ss_n_a && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (ss_n_a !== 1'b0) begin fails++; $display("FAIL en_high_start: got SS_n %b expected 0", ss_n_a); end
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        wait_conv();
        checks++; if (smpl_vld_a !== 4'b0001) begin fails++; $display("FAIL en_drop_vld: got %b expected 0001", smpl_vld_a); end
        checks++; if (result_a[11:0] !== 12'hABC) begin fails++; $display("FAIL en_drop_result: got %h expected abc", result_a[11:0]); end
        repeat (300) @(posedge clk); #1;
        checks++; if (frames_started - f0 != 2) begin fails++; $display("FAIL en_drop_frames: got %0d expected 2", frames_started - f0); end
        en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_default();
        test_round_robin();
        test_num_ch3();
        test_ema();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
